// File: rtl/fifo_rd_stream_adapter.sv
// Read-side front end for a synchronous block-RAM FIFO: issues rd_en, absorbs the fixed read
// latency in a small prefetch ring, and presents a valid/ready pixel stream with line markers.
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH   = 24,
    parameter int RD_LATENCY   = 1,
    parameter int BUF_DEPTH    = 4,
    parameter int PIX_PER_LINE = 1920
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sol,
    output logic                  m_eol,
    output logic                  underrun_err
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 2;
    localparam logic [15:0] LAST_PIX = 16'(PIX_PER_LINE - 1);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [15:0]           pix_cnt_q, pix_cnt_d;
    logic                  underrun_q, underrun_d;

    logic                  xfer;
    logic                  exit_bit;
    logic                  drop;
    logic                  push;
    logic [CNT_W-1:0]      occ_after_pop;
    logic [SUM_W-1:0]      pending;

    function automatic logic [CNT_W-1:0] popcount(input logic [RD_LATENCY-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    assign m_valid      = (count_q != '0);
    assign m_data       = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_sol        = m_valid && (pix_cnt_q == 16'd0);
    assign m_eol        = m_valid && (pix_cnt_q == LAST_PIX);
    assign underrun_err = underrun_q;

    always_comb begin
        xfer          = m_valid && m_ready;
        exit_bit      = inflight_q[RD_LATENCY-1];
        drop          = exit_bit && (discard_q != '0);
        // The word leaving the pipe during a flush is lost with the rest of the buffer.
        push          = exit_bit && !drop && !flush;
        occ_after_pop = count_q - CNT_W'(xfer);
        pending       = SUM_W'(occ_after_pop) + SUM_W'(popcount(inflight_q)) + SUM_W'(discard_q);
        // Gated by reset so no read can be issued while the tracking state is held cleared.
        fifo_rd_en    = rd_rst_n && !fifo_rd_empty && !flush && (pending < SUM_W'(BUF_DEPTH));

        inflight_d    = (inflight_q << 1) | RD_LATENCY'(fifo_rd_en);
        discard_d     = discard_q - CNT_W'(drop);
        if (flush) begin
            discard_d = discard_d + popcount(inflight_d);
        end

        count_d    = count_q + CNT_W'(push) - CNT_W'(xfer);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(xfer);
        pix_cnt_d  = pix_cnt_q;
        if (xfer) begin
            pix_cnt_d = (pix_cnt_q == LAST_PIX) ? 16'd0 : pix_cnt_q + 16'd1;
        end
        underrun_d = underrun_q || (m_ready && !m_valid && (pix_cnt_q != 16'd0));

        if (flush) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            pix_cnt_d  = 16'd0;
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            discard_q  <= '0;
            inflight_q <= '0;
            pix_cnt_q  <= 16'd0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            discard_q  <= discard_d;
            inflight_q <= inflight_d;
            pix_cnt_q  <= pix_cnt_d;
            underrun_q <= underrun_d;
        end
    end

    // Pixel storage carries no reset; outputs are masked by m_valid instead.
    always_ff @(posedge rd_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= fifo_rd_data;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench: two adapters (read latency 1 and 2) fed by FIFO models with identical contents and
// checked against a stream-level scoreboard of words read, delivered and flushed.
module tb_fifo_rd_stream_adapter;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int PPL   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic m_ready = 1'b0;

    logic          rd_en0, vld0, sol0, eol0, und0;
    logic          empty0 = 1'b1;
    logic [DW-1:0] rdata0 = '0;
    logic [DW-1:0] data0;
    logic          rd_en1, vld1, sol1, eol1, und1;
    logic          empty1 = 1'b1;
    logic [DW-1:0] rdata1 = '0;
    logic [DW-1:0] s1_pipe = '0;
    logic [DW-1:0] data1;

    logic [DW-1:0] fmem [0:1023];
    int ftail  = 0;
    int fhead0 = 0;
    int fhead1 = 0;

    int            exp_lo [2];
    int            cnt    [2];
    logic          und_m  [2];
    logic          stall  [2];
    logic [DW+1:0] prev   [2];

    int checks = 0;
    int errors = 0;

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(1), .BUF_DEPTH(DEPTH), .PIX_PER_LINE(PPL)) u_l1 (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(rd_en0), .fifo_rd_data(rdata0),
        .fifo_rd_empty(empty0), .flush(flush), .m_valid(vld0), .m_ready(m_ready),
        .m_data(data0), .m_sol(sol0), .m_eol(eol0), .underrun_err(und0));

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .RD_LATENCY(2), .BUF_DEPTH(DEPTH), .PIX_PER_LINE(PPL)) u_l2 (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_en(rd_en1), .fifo_rd_data(rdata1),
        .fifo_rd_empty(empty1), .flush(flush), .m_valid(vld1), .m_ready(m_ready),
        .m_data(data1), .m_sol(sol1), .m_eol(eol1), .underrun_err(und1));

    // FIFO models: registered empty flag, fixed read latency.
    always @(posedge clk) begin
        if (rd_en0 && fhead0 < ftail) begin
            rdata0 <= fmem[fhead0[9:0]];
            fhead0 <= fhead0 + 1;
            empty0 <= (ftail == fhead0 + 1);
        end else begin
            empty0 <= (ftail == fhead0);
        end
    end

    always @(posedge clk) begin
        rdata1 <= s1_pipe;
        if (rd_en1 && fhead1 < ftail) begin
            s1_pipe <= fmem[fhead1[9:0]];
            fhead1  <= fhead1 + 1;
            empty1  <= (ftail == fhead1 + 1);
        end else begin
            empty1  <= (ftail == fhead1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks = checks + 1;
        assert (obs === want) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fmem[ftail[9:0]] = w;
        ftail = ftail + 1;
    endtask

    // Scoreboard step for one DUT, evaluated mid-cycle for the upcoming edge.
    task automatic score(input int d, input int fh, input logic rd_en, input logic empty,
                         input logic vld, input logic [DW-1:0] data, input logic sol,
                         input logic eol, input logic und, input int occ);
        string p;
        p = (d == 0) ? "lat1" : "lat2";
        if (!rst_n) begin
            exp_lo[d] = fh;
            cnt[d]    = 0;
            und_m[d]  = 1'b0;
            stall[d]  = 1'b0;
            return;
        end
        chk({p, "_rd_en_while_empty"}, 32'(rd_en && empty), 32'd0);
        chk({p, "_occupancy_le_depth"}, 32'(occ <= DEPTH), 32'd1);
        chk({p, "_underrun"}, 32'(und), 32'(und_m[d]));
        if (stall[d]) begin
            chk({p, "_stall_hold"}, 32'({vld, sol, eol, data}), 32'({1'b1, prev[d]}));
        end
        if (vld && m_ready) begin
            chk({p, "_word_expected"}, 32'(exp_lo[d] < fh), 32'd1);
            chk({p, "_data"}, 32'(data), 32'(fmem[exp_lo[d][9:0]]));
            chk({p, "_sol_eol"}, 32'({sol, eol}), 32'({cnt[d] == 0, cnt[d] == PPL - 1}));
            exp_lo[d] = exp_lo[d] + 1;
            cnt[d]    = (cnt[d] + 1) % PPL;
        end
        if (flush) begin
            und_m[d]  = 1'b0;
            exp_lo[d] = fh;
            cnt[d]    = 0;
        end else if (m_ready && !vld && cnt[d] != 0) begin
            und_m[d] = 1'b1;
        end
        stall[d] = vld && !m_ready && !flush;
        prev[d]  = {sol, eol, data};
    endtask

    always @(negedge clk) begin
        score(0, fhead0, rd_en0, empty0, vld0, data0, sol0, eol0, und0, int'(u_l1.count_q));
        score(1, fhead1, rd_en1, empty1, vld1, data1, sol1, eol1, und1, int'(u_l2.count_q));
    end

    initial begin
        int fr [2];
        int fv [2];
        int lv [2];
        int nv [2];

        repeat (3) tick();
        chk("reset_outputs_lat1", 32'({rd_en0, vld0, sol0, eol0, und0, data0}), 32'd0);
        chk("reset_outputs_lat2", 32'({rd_en1, vld1, sol1, eol1, und1, data1}), 32'd0);
        rst_n = 1'b1;

        // Preloaded FIFO, continuous ready: latency and sustained rate.
        for (int i = 1; i <= 16; i++) push(DW'(i));
        m_ready = 1'b1;
        fr = '{-1, -1}; fv = '{-1, -1}; lv = '{-1, -1}; nv = '{0, 0};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rd_en0 && fr[0] < 0) fr[0] = c;
            if (rd_en1 && fr[1] < 0) fr[1] = c;
            if (vld0) begin if (fv[0] < 0) fv[0] = c; lv[0] = c; nv[0]++; end
            if (vld1) begin if (fv[1] < 0) fv[1] = c; lv[1] = c; nv[1]++; end
        end
        chk("lat1_first_valid_delay", 32'(fv[0] - fr[0]), 32'd2);
        chk("lat2_first_valid_delay", 32'(fv[1] - fr[1]), 32'd3);
        chk("lat1_valid_cycles", 32'(nv[0]), 32'd16);
        chk("lat2_valid_cycles", 32'(nv[1]), 32'd16);
        chk("lat1_back_to_back", 32'(lv[0] - fv[0]), 32'd15);
        chk("lat2_back_to_back", 32'(lv[1] - fv[1]), 32'd15);

        // 64 words with ready toggling every cycle.
        tick();
        for (int i = 0; i < 64; i++) push(DW'($urandom));
        for (int i = 0; i < 200; i++) begin
            m_ready = ~m_ready;
            tick();
        end
        m_ready = 1'b1;
        repeat (4) tick();
        chk("lat1_all_64_delivered", 32'(exp_lo[0]), 32'(ftail));
        chk("lat2_all_64_delivered", 32'(exp_lo[1]), 32'(ftail));

        // Three full lines for marker placement.
        for (int i = 0; i < 12; i++) push(DW'(32'h100 + i));
        repeat (30) tick();
        chk("lat1_lines_delivered", 32'(exp_lo[0]), 32'(ftail));
        chk("lat2_lines_delivered", 32'(exp_lo[1]), 32'(ftail));

        // FIFO runs dry mid-line.
        push(24'h0000AA);
        push(24'h0000BB);
        repeat (10) tick();
        chk("lat1_underrun_set", 32'(und0), 32'd1);
        chk("lat2_underrun_set", 32'(und1), 32'd1);
        repeat (5) tick();
        chk("lat1_underrun_sticky", 32'(und0), 32'd1);
        chk("lat2_underrun_sticky", 32'(und1), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("lat1_underrun_cleared", 32'(und0), 32'd0);
        chk("lat2_underrun_cleared", 32'(und1), 32'd0);
        tick();

        // Flush right after two back-to-back reads.
        push(24'h00C0DE);
        push(24'h00BEEF);
        tick();
        chk("rd_en_first_read", 32'({rd_en0, rd_en1}), 32'b11);
        tick();
        chk("rd_en_second_read", 32'({rd_en0, rd_en1}), 32'b11);
        tick();
        flush = 1'b1;
        chk("lat2_no_valid_flush_cycle", 32'(vld1), 32'd0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lat2_inflight_discarded", 32'(vld1), 32'd0);
            tick();
        end
        push(24'hABCDEF);
        repeat (10) tick();
        chk("lat1_after_flush_delivered", 32'(exp_lo[0]), 32'(ftail));
        chk("lat2_after_flush_delivered", 32'(exp_lo[1]), 32'(ftail));

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 8; i++) push(DW'(32'h200 + i));
        repeat (5) tick();
        chk("streaming_before_reset", 32'({vld0, vld1}), 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_lat1", 32'({rd_en0, vld0, sol0, eol0, und0, data0}), 32'd0);
        chk("async_reset_lat2", 32'({rd_en1, vld1, sol1, eol1, und1, data1}), 32'd0);
        #12;
        rst_n = 1'b1;
        repeat (25) tick();
        chk("lat1_resume_after_reset", 32'(exp_lo[0]), 32'(ftail));
        chk("lat2_resume_after_reset", 32'(exp_lo[1]), 32'(ftail));

        // Random traffic, stalls and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) != 0 && ftail < 1000) push(DW'($urandom));
            tick();
        end
        m_ready = 1'b1;
        flush   = 1'b0;
        repeat (150) tick();
        chk("lat1_random_drained", 32'(exp_lo[0]), 32'(ftail));
        chk("lat2_random_drained", 32'(exp_lo[1]), 32'(ftail));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
